// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: holds the fetch PC, issues requests on the SRAM-like bus and hands words to ID.
// Define IF_ADEL_EN to raise AdEL on misaligned fetch PCs; otherwise the PC low bits are ignored on the bus.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [4:0]  ADEL_CODE = 5'h04
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_allowin_in,
    input  logic [31:0] id_nextPC_in,
    input  logic        wb_ClrStpJmp_in,
    input  logic [31:0] wb_cp0_res_in,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid_out,
    output logic [31:0] if_PC_out,
    output logic [31:0] if_NPC_out,
    output logic [31:0] if_NNPC_out,
    output logic [31:0] if_Instruct_out,
    output logic [31:0] if_NPC_fast_out,
    output logic        if_exception_out,
    output logic [4:0]  if_ExcCode_out,
    output logic [31:0] if_error_VAddr_out
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_CANC = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic [31:0] r_fpc;
    logic [31:0] r_fpcIss;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic [31:0] r_nnpc;
    logic [31:0] r_inst;
    logic        r_exc;
    logic [4:0]  r_excCode;
    logic [31:0] r_vaddr;
    logic [31:0] r_pendPc;
    logic [31:0] r_pendInst;

    logic        w_consume;
    logic        w_free;
    logic        w_misaligned;
    logic        w_handshake;
    logic        w_busLoad;
    logic        w_park;
    logic        w_pendLoad;
    logic        w_excLoad;
    logic        w_slotLoad;
    logic [31:0] w_loadPc;
    logic [31:0] w_loadInst;

`ifdef IF_ADEL_EN
    assign w_misaligned = (r_fpc[1:0] != 2'b00);
    assign inst_addr    = r_fpc;
`else
    assign w_misaligned = 1'b0;
    assign inst_addr    = {r_fpc[31:2], 2'b00};
`endif

    assign w_consume   = r_valid & id_allowin_in;
    assign w_free      = ~r_valid | w_consume;
    assign inst_req    = rst_n & (r_state == S_REQ) & w_free & ~w_misaligned;
    assign w_handshake = inst_req & inst_addr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_busLoad   = 1'b0;
        w_park      = 1'b0;
        w_pendLoad  = 1'b0;
        w_excLoad   = 1'b0;
        case (r_state)
            S_REQ: begin
                if (w_handshake) begin
                    w_stateNext = S_WAIT;
                end
                w_excLoad = w_free & w_misaligned;
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    if (w_free) begin
                        w_busLoad   = 1'b1;
                        w_stateNext = S_REQ;
                    end else begin
                        w_park      = 1'b1;
                        w_stateNext = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_consume) begin
                    w_pendLoad  = 1'b1;
                    w_stateNext = S_REQ;
                end
            end
            S_CANC: begin
                if (inst_data_ok) begin
                    w_stateNext = S_REQ;
                end
            end
            default: w_stateNext = S_REQ;
        endcase
        // A flush leaves S_CANC behind whenever a bus response is still owed, so the stale word is swallowed.
        if (wb_ClrStpJmp_in) begin
            w_busLoad  = 1'b0;
            w_park     = 1'b0;
            w_pendLoad = 1'b0;
            w_excLoad  = 1'b0;
            if (w_handshake || (((r_state == S_WAIT) || (r_state == S_CANC)) && !inst_data_ok)) begin
                w_stateNext = S_CANC;
            end else begin
                w_stateNext = S_REQ;
            end
        end
    end

    assign w_slotLoad = w_busLoad | w_pendLoad | w_excLoad;
    assign w_loadPc   = w_pendLoad ? r_pendPc   : (w_excLoad ? r_fpc : r_fpcIss);
    assign w_loadInst = w_pendLoad ? r_pendInst : (w_excLoad ? 32'h0 : inst_rdata);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc      <= RESET_PC;
            r_fpcIss   <= 32'h0;
            r_valid    <= 1'b0;
            r_pc       <= 32'h0;
            r_npc      <= 32'h0;
            r_nnpc     <= 32'h0;
            r_inst     <= 32'h0;
            r_exc      <= 1'b0;
            r_excCode  <= 5'h0;
            r_vaddr    <= 32'h0;
            r_pendPc   <= 32'h0;
            r_pendInst <= 32'h0;
        end else begin
            if (wb_ClrStpJmp_in) begin
                r_fpc <= wb_cp0_res_in;
            end else if (w_handshake || w_excLoad) begin
                r_fpc <= id_nextPC_in;
            end
            if (w_handshake) begin
                r_fpcIss <= r_fpc;
            end
            if (w_park) begin
                r_pendPc   <= r_fpcIss;
                r_pendInst <= inst_rdata;
            end
            if (wb_ClrStpJmp_in) begin
                r_valid <= 1'b0;
            end else if (w_slotLoad) begin
                r_valid   <= 1'b1;
                r_pc      <= w_loadPc;
                r_npc     <= w_loadPc + 32'd4;
                r_nnpc    <= w_loadPc + 32'd8;
                r_inst    <= w_loadInst;
                r_exc     <= w_excLoad;
                r_excCode <= w_excLoad ? ADEL_CODE : 5'h0;
                r_vaddr   <= w_excLoad ? r_fpc : 32'h0;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign if_valid_out       = r_valid;
    assign if_PC_out          = r_pc;
    assign if_NPC_out         = r_npc;
    assign if_NNPC_out        = r_nnpc;
    assign if_Instruct_out    = r_inst;
    assign if_NPC_fast_out    = r_fpc + 32'd4;
    assign if_exception_out   = r_exc;
    assign if_ExcCode_out     = r_excCode;
    assign if_error_VAddr_out = r_vaddr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a randomized run against a
// transaction-level model of the fetch stream. Honours IF_ADEL_EN like the design.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst_n;
    logic        id_allowin_in;
    logic [31:0] id_nextPC_in;
    logic        wb_ClrStpJmp_in;
    logic [31:0] wb_cp0_res_in;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid_out;
    logic [31:0] if_PC_out;
    logic [31:0] if_NPC_out;
    logic [31:0] if_NNPC_out;
    logic [31:0] if_Instruct_out;
    logic [31:0] if_NPC_fast_out;
    logic        if_exception_out;
    logic [4:0]  if_ExcCode_out;
    logic [31:0] if_error_VAddr_out;

    int checks = 0;
    int errors = 0;
    bit followFast = 1'b1;

    if_fetch_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_allowin_in     (id_allowin_in),
        .id_nextPC_in      (id_nextPC_in),
        .wb_ClrStpJmp_in   (wb_ClrStpJmp_in),
        .wb_cp0_res_in     (wb_cp0_res_in),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_addr_ok      (inst_addr_ok),
        .inst_data_ok      (inst_data_ok),
        .inst_rdata        (inst_rdata),
        .if_valid_out      (if_valid_out),
        .if_PC_out         (if_PC_out),
        .if_NPC_out        (if_NPC_out),
        .if_NNPC_out       (if_NNPC_out),
        .if_Instruct_out   (if_Instruct_out),
        .if_NPC_fast_out   (if_NPC_fast_out),
        .if_exception_out  (if_exception_out),
        .if_ExcCode_out    (if_ExcCode_out),
        .if_error_VAddr_out(if_error_VAddr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired (time limit)");
        $fatal(1, "[TB] watchdog");
    end

    // Instruction memory contents as seen by the bench
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // Program flow used in the random run: occasional forward jumps, otherwise sequential
    function automatic logic [31:0] flowNext(input logic [31:0] pc);
        return (pc[5:2] == 4'd9) ? pc + 32'h0000_0114 : pc + 32'd4;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (followFast) id_nextPC_in = if_NPC_fast_out;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        id_allowin_in = 1'b0; wb_ClrStpJmp_in = 1'b0; wb_cp0_res_in = 32'h0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        followFast = 1'b1; id_nextPC_in = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        id_nextPC_in = if_NPC_fast_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        id_allowin_in = 1'b1; wb_ClrStpJmp_in = 1'b0; wb_cp0_res_in = 32'h0;
        inst_addr_ok = 1'b1; inst_data_ok = 1'b0; inst_rdata = 32'h0; id_nextPC_in = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got=%0b exp=0", inst_req); end
        checks++; if (if_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%0b exp=0", if_valid_out); end
        checks++; if (if_PC_out !== 32'h0 || if_NPC_out !== 32'h0 || if_NNPC_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_pcs got=%h/%h/%h exp=0/0/0", if_PC_out, if_NPC_out, if_NNPC_out); end
        checks++; if (if_Instruct_out !== 32'h0 || if_exception_out !== 1'b0 || if_ExcCode_out !== 5'h0 || if_error_VAddr_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_slot got=%h/%0b/%h/%h exp=0", if_Instruct_out, if_exception_out, if_ExcCode_out, if_error_VAddr_out); end
        checks++; if (if_NPC_fast_out !== RESET_PC + 32'd4) begin errors++; $display("[TB] FAIL reset_fast got=%h exp=%h", if_NPC_fast_out, RESET_PC + 32'd4); end
    endtask

    task automatic test_basic_fetch();
        apply_reset();
        id_allowin_in = 1'b1; inst_addr_ok = 1'b1; #1;
        checks++; if (inst_req !== 1'b1 || inst_addr !== RESET_PC) begin errors++; $display("[TB] FAIL t1_req got=%0b/%h exp=1/%h", inst_req, inst_addr, RESET_PC); end
        tick(); inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001; inst_addr_ok = 1'b0; #1;
        checks++; if (inst_req !== 1'b0 || if_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL t1_wait got req=%0b valid=%0b exp=0/0", inst_req, if_valid_out); end
        tick(); inst_data_ok = 1'b0; #1;
        checks++; if (if_valid_out !== 1'b1 || if_PC_out !== 32'hBFC0_0000) begin errors++; $display("[TB] FAIL t1_slot got=%0b/%h exp=1/bfc00000", if_valid_out, if_PC_out); end
        checks++; if (if_NPC_out !== 32'hBFC0_0004 || if_NNPC_out !== 32'hBFC0_0008) begin errors++; $display("[TB] FAIL t1_npc got=%h/%h exp=bfc00004/bfc00008", if_NPC_out, if_NNPC_out); end
        checks++; if (if_Instruct_out !== 32'h2408_0001 || if_exception_out !== 1'b0) begin errors++; $display("[TB] FAIL t1_inst got=%h/%0b exp=24080001/0", if_Instruct_out, if_exception_out); end
    endtask

    task automatic test_stall();
        apply_reset();
        id_allowin_in = 1'b0; inst_addr_ok = 1'b1;
        tick(); inst_data_ok = 1'b1; inst_rdata = memWord(RESET_PC);
        tick(); inst_data_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (if_valid_out !== 1'b1 || if_PC_out !== RESET_PC) begin errors++; $display("[TB] FAIL t2_hold%0d got=%0b/%h exp=1/%h", i, if_valid_out, if_PC_out, RESET_PC); end
            checks++; if (inst_req !== 1'b0) begin errors++; $display("[TB] FAIL t2_noreq%0d got=%0b exp=0", i, inst_req); end
            tick();
        end
        id_allowin_in = 1'b1; #1;
        checks++; if (inst_req !== 1'b1 || inst_addr !== RESET_PC + 32'd4) begin errors++; $display("[TB] FAIL t2_req2 got=%0b/%h exp=1/%h", inst_req, inst_addr, RESET_PC + 32'd4); end
        checks++; if (if_Instruct_out !== memWord(RESET_PC)) begin errors++; $display("[TB] FAIL t2_word1 got=%h exp=%h", if_Instruct_out, memWord(RESET_PC)); end
        tick(); inst_data_ok = 1'b1; inst_rdata = memWord(RESET_PC + 32'd4); #1;
        checks++; if (if_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL t2_gap got=%0b exp=0", if_valid_out); end
        tick(); inst_data_ok = 1'b0; #1;
        checks++; if (if_valid_out !== 1'b1 || if_PC_out !== RESET_PC + 32'd4 || if_Instruct_out !== memWord(RESET_PC + 32'd4)) begin errors++; $display("[TB] FAIL t2_word2 got=%0b/%h/%h exp=1/%h/%h", if_valid_out, if_PC_out, if_Instruct_out, RESET_PC + 32'd4, memWord(RESET_PC + 32'd4)); end
    endtask

    task automatic test_flush_wait();
        apply_reset();
        id_allowin_in = 1'b1; inst_addr_ok = 1'b1;
        tick(); wb_ClrStpJmp_in = 1'b1; wb_cp0_res_in = 32'hBFC0_0380;
        tick(); wb_ClrStpJmp_in = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF; #1;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("[TB] FAIL t3_cancel_req got=%0b exp=0", inst_req); end
        tick(); inst_data_ok = 1'b0; #1;
        checks++; if (if_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL t3_discard got=%0b exp=0", if_valid_out); end
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0380) begin errors++; $display("[TB] FAIL t3_target got=%0b/%h exp=1/bfc00380", inst_req, inst_addr); end
        tick(); inst_data_ok = 1'b1; inst_rdata = memWord(32'hBFC0_0380);
        tick(); inst_data_ok = 1'b0; #1;
        checks++; if (if_valid_out !== 1'b1 || if_PC_out !== 32'hBFC0_0380 || if_Instruct_out !== memWord(32'hBFC0_0380)) begin errors++; $display("[TB] FAIL t3_deliver got=%0b/%h/%h exp=1/bfc00380/%h", if_valid_out, if_PC_out, if_Instruct_out, memWord(32'hBFC0_0380)); end
    endtask

    task automatic test_flush_data();
        apply_reset();
        id_allowin_in = 1'b1; inst_addr_ok = 1'b1;
        tick(); wb_ClrStpJmp_in = 1'b1; wb_cp0_res_in = 32'hBFC0_0200; inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        tick(); wb_ClrStpJmp_in = 1'b0; inst_data_ok = 1'b0; #1;
        checks++; if (if_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL t4_discard got=%0b exp=0", if_valid_out); end
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0200) begin errors++; $display("[TB] FAIL t4_target got=%0b/%h exp=1/bfc00200", inst_req, inst_addr); end
        tick(); inst_data_ok = 1'b1; inst_rdata = memWord(32'hBFC0_0200);
        tick(); inst_data_ok = 1'b0; #1;
        checks++; if (if_valid_out !== 1'b1 || if_PC_out !== 32'hBFC0_0200) begin errors++; $display("[TB] FAIL t4_deliver got=%0b/%h exp=1/bfc00200", if_valid_out, if_PC_out); end
    endtask

    task automatic test_misaligned();
        apply_reset();
        followFast = 1'b0; id_nextPC_in = 32'h8000_0002;
        id_allowin_in = 1'b0; inst_addr_ok = 1'b1;
        tick(); inst_data_ok = 1'b1; inst_rdata = memWord(RESET_PC);
        tick(); inst_data_ok = 1'b0; id_allowin_in = 1'b1; id_nextPC_in = 32'hBFC0_0100; #1;
`ifdef IF_ADEL_EN
        checks++; if (inst_req !== 1'b0) begin errors++; $display("[TB] FAIL t5_noreq got=%0b exp=0", inst_req); end
        tick(); id_allowin_in = 1'b0; #1;
        checks++; if (if_valid_out !== 1'b1 || if_exception_out !== 1'b1 || if_ExcCode_out !== 5'h04) begin errors++; $display("[TB] FAIL t5_exc got=%0b/%0b/%h exp=1/1/04", if_valid_out, if_exception_out, if_ExcCode_out); end
        checks++; if (if_error_VAddr_out !== 32'h8000_0002 || if_PC_out !== 32'h8000_0002 || if_Instruct_out !== 32'h0) begin errors++; $display("[TB] FAIL t5_vaddr got=%h/%h/%h exp=80000002/80000002/0", if_error_VAddr_out, if_PC_out, if_Instruct_out); end
        checks++; if (if_NPC_out !== 32'h8000_0006) begin errors++; $display("[TB] FAIL t5_npc got=%h exp=80000006", if_NPC_out); end
        id_allowin_in = 1'b1; #1;
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0100) begin errors++; $display("[TB] FAIL t5_resume got=%0b/%h exp=1/bfc00100", inst_req, inst_addr); end
`else
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h8000_0000) begin errors++; $display("[TB] FAIL t5_aligned_req got=%0b/%h exp=1/80000000", inst_req, inst_addr); end
        tick(); inst_data_ok = 1'b1; inst_rdata = memWord(32'h8000_0000);
        tick(); inst_data_ok = 1'b0; #1;
        checks++; if (if_valid_out !== 1'b1 || if_PC_out !== 32'h8000_0002 || if_exception_out !== 1'b0) begin errors++; $display("[TB] FAIL t5_noexc got=%0b/%h/%0b exp=1/80000002/0", if_valid_out, if_PC_out, if_exception_out); end
        checks++; if (if_Instruct_out !== memWord(32'h8000_0000) || if_ExcCode_out !== 5'h0 || if_error_VAddr_out !== 32'h0) begin errors++; $display("[TB] FAIL t5_word got=%h/%h/%h exp=%h/0/0", if_Instruct_out, if_ExcCode_out, if_error_VAddr_out, memWord(32'h8000_0000)); end
`endif
        followFast = 1'b1;
    endtask

    task automatic test_reset_midwait();
        apply_reset();
        id_allowin_in = 1'b1; inst_addr_ok = 1'b1;
        tick(); inst_data_ok = 1'b1; inst_rdata = memWord(RESET_PC);
        tick(); inst_data_ok = 1'b0; #1;
        checks++; if (if_valid_out !== 1'b1 || inst_req !== 1'b1 || inst_addr !== RESET_PC + 32'd4) begin errors++; $display("[TB] FAIL t6_pre got=%0b/%0b/%h exp=1/1/%h", if_valid_out, inst_req, inst_addr, RESET_PC + 32'd4); end
        tick(); #1;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("[TB] FAIL t6_wait got=%0b exp=0", inst_req); end
        #2 rst_n = 1'b0; #1;
        checks++; if (if_valid_out !== 1'b0 || if_PC_out !== 32'h0 || if_NPC_out !== 32'h0 || if_NNPC_out !== 32'h0 || if_Instruct_out !== 32'h0) begin errors++; $display("[TB] FAIL t6_clear got=%0b/%h/%h/%h/%h exp=0", if_valid_out, if_PC_out, if_NPC_out, if_NNPC_out, if_Instruct_out); end
        checks++; if (inst_req !== 1'b0 || inst_addr !== RESET_PC) begin errors++; $display("[TB] FAIL t6_reqclr got=%0b/%h exp=0/%h", inst_req, inst_addr, RESET_PC); end
        tick(); tick();
        rst_n = 1'b1; id_nextPC_in = if_NPC_fast_out; #1;
        checks++; if (inst_req !== 1'b1 || inst_addr !== RESET_PC) begin errors++; $display("[TB] FAIL t6_restart got=%0b/%h exp=1/%h", inst_req, inst_addr, RESET_PC); end
        tick(); inst_data_ok = 1'b1; inst_rdata = memWord(RESET_PC);
        tick(); inst_data_ok = 1'b0; #1;
        checks++; if (if_valid_out !== 1'b1 || if_PC_out !== RESET_PC || if_Instruct_out !== memWord(RESET_PC)) begin errors++; $display("[TB] FAIL t6_deliver got=%0b/%h/%h exp=1/%h/%h", if_valid_out, if_PC_out, if_Instruct_out, RESET_PC, memWord(RESET_PC)); end
    endtask

    task automatic test_wrap();
        apply_reset();
        id_allowin_in = 1'b1; inst_addr_ok = 1'b0;
        wb_ClrStpJmp_in = 1'b1; wb_cp0_res_in = 32'hFFFF_FFF8;
        tick(); wb_ClrStpJmp_in = 1'b0; inst_addr_ok = 1'b1; #1;
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hFFFF_FFF8 || if_NPC_fast_out !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_req got=%0b/%h/%h exp=1/fffffff8/fffffffc", inst_req, inst_addr, if_NPC_fast_out); end
        tick(); #1;
        checks++; if (if_NPC_fast_out !== 32'h0) begin errors++; $display("[TB] FAIL wrap_fast got=%h exp=0", if_NPC_fast_out); end
        inst_data_ok = 1'b1; inst_rdata = memWord(32'hFFFF_FFF8);
        tick(); inst_data_ok = 1'b0; #1;
        checks++; if (if_PC_out !== 32'hFFFF_FFF8 || if_NPC_out !== 32'hFFFF_FFFC || if_NNPC_out !== 32'h0) begin errors++; $display("[TB] FAIL wrap_slot1 got=%h/%h/%h exp=fffffff8/fffffffc/0", if_PC_out, if_NPC_out, if_NNPC_out); end
        tick(); inst_data_ok = 1'b1; inst_rdata = memWord(32'hFFFF_FFFC);
        tick(); inst_data_ok = 1'b0; #1;
        checks++; if (if_valid_out !== 1'b1 || if_PC_out !== 32'hFFFF_FFFC || if_NPC_out !== 32'h0 || if_NNPC_out !== 32'h4) begin errors++; $display("[TB] FAIL wrap_slot2 got=%0b/%h/%h/%h exp=1/fffffffc/0/4", if_valid_out, if_PC_out, if_NPC_out, if_NNPC_out); end
    endtask

    task automatic test_random();
        logic [31:0] reqPc, delivPc, outAddr, prevAddr;
        logic        outValid, prevStall, lastFlush, hs;
        int          delivered;
        apply_reset();
        followFast = 1'b0;
        reqPc = RESET_PC; delivPc = RESET_PC;
        outValid = 1'b0; outAddr = 32'h0; prevStall = 1'b0; prevAddr = 32'h0; lastFlush = 1'b0;
        delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            id_allowin_in   = ($urandom_range(0, 9) < 6);
            inst_addr_ok    = ($urandom_range(0, 9) < 7);
            wb_ClrStpJmp_in = ($urandom_range(0, 19) == 0);
            wb_cp0_res_in   = RESET_PC + ($urandom_range(0, 1023) << 2);
            inst_data_ok    = outValid && ($urandom_range(0, 1) == 1);
            inst_rdata      = inst_data_ok ? memWord(outAddr) : $urandom;
            id_nextPC_in    = flowNext(if_NPC_fast_out - 32'd4);
            #1;
            hs = inst_req && inst_addr_ok;
            if (prevStall && !lastFlush) begin
                checks++; if (inst_req !== 1'b1 || inst_addr !== prevAddr) begin errors++; $display("[TB] FAIL rnd_stable cyc=%0d got=%0b/%h exp=1/%h", cyc, inst_req, inst_addr, prevAddr); end
            end
            if (hs) begin
                checks++; if (outValid) begin errors++; $display("[TB] FAIL rnd_outstanding cyc=%0d got=2 exp<=1", cyc); end
                checks++; if (inst_addr !== reqPc) begin errors++; $display("[TB] FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, inst_addr, reqPc); end
                reqPc = flowNext(reqPc);
            end
            if (if_valid_out && id_allowin_in && !wb_ClrStpJmp_in) begin
                checks++; if (if_PC_out !== delivPc) begin errors++; $display("[TB] FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, if_PC_out, delivPc); end
                checks++; if (if_Instruct_out !== memWord(delivPc)) begin errors++; $display("[TB] FAIL rnd_inst cyc=%0d got=%h exp=%h", cyc, if_Instruct_out, memWord(delivPc)); end
                checks++; if (if_NPC_out !== delivPc + 32'd4 || if_NNPC_out !== delivPc + 32'd8) begin errors++; $display("[TB] FAIL rnd_npc cyc=%0d got=%h/%h exp=%h/%h", cyc, if_NPC_out, if_NNPC_out, delivPc + 32'd4, delivPc + 32'd8); end
                checks++; if (if_exception_out !== 1'b0) begin errors++; $display("[TB] FAIL rnd_exc cyc=%0d got=%0b exp=0", cyc, if_exception_out); end
                delivPc = flowNext(delivPc);
                delivered++;
            end
            if (wb_ClrStpJmp_in) begin
                reqPc   = wb_cp0_res_in;
                delivPc = wb_cp0_res_in;
            end
            if (inst_data_ok) outValid = 1'b0;
            if (hs) begin
                outValid = 1'b1;
                outAddr  = inst_addr;
            end
            prevStall = inst_req && !inst_addr_ok;
            prevAddr  = inst_addr;
            lastFlush = wb_ClrStpJmp_in;
        end
        @(negedge clk);
        wb_ClrStpJmp_in = 1'b0; inst_data_ok = 1'b0; inst_addr_ok = 1'b0;
        checks++; if (delivered < 100) begin errors++; $display("[TB] FAIL rnd_progress got=%0d exp>=100", delivered); end
        followFast = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_flush_wait();
        test_flush_data();
        test_misaligned();
        test_reset_midwait();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
